fcvt_sched: RTL and testbench
=============================

Name: fcvt_sched

Overview:
- Shares one int-to-single conversion datapath (the team's FCVT_S_WU unit) between N_REQ requesters: integer pipe, CSR/debug path, and others.
- Round-robin arbitration; operand and result registered; valid/ready on both sides.
- Sequences signed conversion (FCVT.S.W) on the unsigned datapath: negate, convert, apply sign.
- Keeps the sticky NX (inexact) bit for fflags.

Parameters:
N_REQ, 2, number of requesters (2..8)
I_WIDTH, 32, integer operand width
F_WIDTH, 32, float result width
TAG_W, 4, opaque per-request tag width returned with result

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  request accepted (one-hot or zero)
req_data  in  N_REQ*I_WIDTH  integer operands, requester i at [i*I_WIDTH +: I_WIDTH]
req_signed  in  N_REQ  1 = FCVT.S.W, 0 = FCVT.S.WU
req_tag  in  N_REQ*TAG_W  tags
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  F_WIDTH  IEEE single result
rsp_id  out  $clog2(N_REQ)  index of granted requester
rsp_tag  out  TAG_W  tag of the request
rsp_inexact  out  1  inexact for this result
fflags_nx  out  1  sticky inexact
fflags_clr  in  1  clear sticky NX
busy  out  1  state != IDLE

Behaviour:
- Reset: async on RSTn low. State = IDLE; rr pointer = 0; rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_inexact, fflags_nx, busy all 0. Operand registers cleared. An in-flight request is dropped and never responded.
- FSM states:
  - IDLE: can_accept = 1. Any req_valid → grant, latch operand, go to CONV.
  - CONV: datapath evaluates the latched magnitude. Result, sign and inexact are registered. Go to RESP.
  - RESP: rsp_valid = 1. On rsp_ready with no new grant → IDLE. On rsp_ready with a new grant in the same cycle → CONV.
- can_accept = (state == IDLE) | (state == RESP & rsp_ready).
- Latency: request handshake at cycle t → rsp_valid at t+2. Peak throughput is one result per 2 cycles.
- Arbitration:
  - Round-robin from pointer p: grant the first i in p, p+1, ... (mod N_REQ) with req_valid[i].
  - req_ready[i] = can_accept & (grant == i).
  - On a grant, p = (grant + 1) mod N_REQ. With no grant, p holds.
  - Grant is combinational from req_valid; requesters must not make valid depend on ready.
- Signed sequencing:
  - At latch time: neg = req_signed & op[I_WIDTH-1]; mag = neg ? -op : op (I_WIDTH-bit two's complement).
  - op = 0x80000000 signed gives mag = 0x80000000, converted correctly as unsigned.
  - Result = {neg & ~zero, datapath result[F_WIDTH-2:0]}. Zero input always gives +0.0.
- Rounding is the datapath's (round-half-up on the guard bit). The scheduler does not alter it.
- Response hold: while rsp_valid & ~rsp_ready, all rsp_* outputs stay stable and no new request is accepted.
- Sticky NX:
  - Set on a response handshake (rsp_valid & rsp_ready & rsp_inexact).
  - fflags_clr clears it on the next edge.
  - Same-cycle clear and set: set wins, fflags_nx = 1.
- busy = (state != IDLE).
- Out-of-range grant indices cannot occur. Assertion: req_ready is onehot0.

Optional Feature:
- Macro: FCVT_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer register is removed and the grant ignores p.
- Undefined: round-robin as above. All other behaviour is identical.

Decomposition:
- Package fcvt_pkg holds:
  - state enum fcvt_state_e {IDLE, CONV, RESP}
  - constants F_EXP_BIAS = 127, F_SIGN_BIT = F_WIDTH-1
- Sub-module fcvt_rr_arb: N_REQ-wide round-robin arbiter with grant index, grant valid, advance input, and the FIXED_PRIO ifdef inside.
- FCVT_S_WU is instantiated once, combinationally, on the latched magnitude.

Test Plan:
- Requester 0: 7 unsigned, rsp_ready=1 → rsp_data 0x40E00000, rsp_inexact 0, rsp_valid exactly 2 cycles after handshake, rsp_id 0.
- Requester 1, signed: -1 (0xFFFFFFFF) → 0xBF800000. Then 0x80000000 signed → 0xCF000000. Then 0 signed → 0x00000000, inexact 0.
- 0xFFFFFFFF unsigned → 0x4F800000, rsp_inexact 1, fflags_nx 1 after handshake. Pulse fflags_clr → 0. Clear and inexact handshake in the same cycle → fflags_nx stays 1.
- Both requesters hold valid for 8 requests, rsp_ready=1 → grants alternate 0,1,0,1. Tags echo correctly. With FCVT_SCHED_FIXED_PRIO_EN → all grants go to 0.
- rsp_ready low for 5 cycles in RESP → rsp_* stable, req_ready all 0. Raise rsp_ready with a pending request → new grant the same cycle, next rsp_valid 2 cycles later.
- RSTn asserted while in CONV → all outputs 0 immediately, no response for the dropped request, first post-reset request serviced normally.

Source files
------------

// File: rtl/fcvt_pkg.sv
// Shared types and constants for the int-to-single conversion scheduler.
package fcvt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } fcvt_state_e;

  localparam int F_EXP_BIAS = 127;
  localparam int F_WIDTH_SP = 32;
  localparam int F_SIGN_BIT = F_WIDTH_SP - 1;

endpackage

// File: rtl/fcvt_rr_arb.sv
// Round-robin request arbiter; FCVT_SCHED_FIXED_PRIO_EN selects lowest-index-wins
// fixed priority and removes the pointer register.
module fcvt_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         valid,
  input  logic                     advance,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_vld
);

  localparam int IW = $clog2(N_REQ);

`ifdef FCVT_SCHED_FIXED_PRIO_EN
  logic unused_ctl;
  assign unused_ctl = ^{clk, rst_n, advance};

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid[k]) begin
        grant_idx = IW'(k);
        grant_vld = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr;

  // Scan downward from the farthest slot so the slot nearest ptr is written last and wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid[(int'(ptr) + k) % N_REQ]) begin
        grant_idx = IW'((int'(ptr) + k) % N_REQ);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/fcvt_s_wu.sv
// FCVT_S_WU: combinational unsigned integer to IEEE single, round-half-up on the guard bit.
module fcvt_s_wu
  import fcvt_pkg::*;
#(
  parameter int I_WIDTH = 32,
  parameter int F_WIDTH = 32
) (
  input  logic [I_WIDTH-1:0] a,
  output logic [F_WIDTH-1:0] f,
  output logic               inexact
);

  localparam int MW    = 23;
  localparam int MSB_W = $clog2(I_WIDTH);

  logic [MSB_W-1:0]   msb;
  logic [I_WIDTH-1:0] norm;
  logic [MW:0]        rnd;
  logic               guard;
  logic               sticky;
  logic [7:0]         expo;
  logic               unused_lead;

  always_comb begin
    msb = '0;
    for (int i = 0; i < I_WIDTH; i++) begin
      if (a[i]) msb = MSB_W'(i);
    end
    norm   = a << (I_WIDTH - 1 - int'(msb));
    guard  = norm[I_WIDTH-MW-2];
    sticky = |norm[I_WIDTH-MW-3:0];
    // A carry out of the mantissa bumps the exponent; the mantissa field wraps to zero.
    rnd    = {1'b0, norm[I_WIDTH-2 -: MW]} + {{MW{1'b0}}, guard};
    expo   = 8'(F_EXP_BIAS + int'(msb) + int'(rnd[MW]));
    inexact = guard | sticky;
    f = '0;
    if (a != '0) f = F_WIDTH'({1'b0, expo, rnd[MW-1:0]});
  end

  assign unused_lead = norm[I_WIDTH-1];

endmodule

// File: rtl/fcvt_sched.sv
// Shares one FCVT_S_WU datapath across N_REQ requesters, adding signed sequencing and
// sticky NX. Define FCVT_SCHED_FIXED_PRIO_EN for fixed-priority arbitration.
module fcvt_sched
  import fcvt_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int I_WIDTH = 32,
  parameter int F_WIDTH = 32,
  parameter int TAG_W   = 4
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*I_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_signed,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [F_WIDTH-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_inexact,
  output logic                       fflags_nx,
  input  logic                       fflags_clr,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);

  fcvt_state_e        state;
  logic               can_accept;
  logic               take;
  logic               grant_vld;
  logic [IW-1:0]      grant_idx;
  logic [I_WIDTH-1:0] op_sel;
  logic               neg_sel;
  logic [I_WIDTH-1:0] mag_sel;
  logic [TAG_W-1:0]   tag_sel;
  logic [I_WIDTH-1:0] op_mag_p0;
  logic               op_neg_p0;
  logic [F_WIDTH-1:0] dp_f;
  logic               dp_inexact;
  logic [F_WIDTH-1:0] res;

  assign can_accept = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign take       = can_accept & grant_vld;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  fcvt_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk       (CLK),
    .rst_n     (RSTn),
    .valid     (req_valid),
    .advance   (take),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant_idx] = 1'b1;
  end

  // Signed operands are negated to a magnitude here; 0x80000000 maps to itself, which the
  // unsigned datapath converts correctly.
  assign op_sel  = req_data[grant_idx*I_WIDTH +: I_WIDTH];
  assign tag_sel = req_tag[grant_idx*TAG_W +: TAG_W];
  assign neg_sel = req_signed[grant_idx] & op_sel[I_WIDTH-1];
  assign mag_sel = neg_sel ? -op_sel : op_sel;

  fcvt_s_wu #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH)) u_cvt (
    .a       (op_mag_p0),
    .f       (dp_f),
    .inexact (dp_inexact)
  );

  always_comb begin
    res = dp_f;
    res[F_SIGN_BIT] = op_neg_p0 & (op_mag_p0 != '0);
  end

  // Stage p0: operand latched at grant; output stage: result registered in CONV.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      op_mag_p0   <= '0;
      op_neg_p0   <= 1'b0;
      rsp_id      <= '0;
      rsp_tag     <= '0;
      rsp_data    <= '0;
      rsp_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (take) state <= CONV;
        CONV:    state <= RESP;
        RESP:    if (rsp_ready) state <= take ? CONV : IDLE;
        default: state <= IDLE;
      endcase
      if (take) begin
        op_mag_p0 <= mag_sel;
        op_neg_p0 <= neg_sel;
        rsp_id    <= grant_idx;
        rsp_tag   <= tag_sel;
      end
      if (state == CONV) begin
        rsp_data    <= res;
        rsp_inexact <= dp_inexact;
      end
    end
  end

  // A set in the same cycle as a clear takes precedence.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fflags_nx <= 1'b0;
    end else if (rsp_valid & rsp_ready & rsp_inexact) begin
      fflags_nx <= 1'b1;
    end else if (fflags_clr) begin
      fflags_nx <= 1'b0;
    end
  end

  a_ready_onehot0: assert property (@(posedge CLK) disable iff (!RSTn) $onehot0(req_ready));

endmodule

// File: tb/tb_fcvt_sched.sv
// Directed bench for fcvt_sched: conversions, sign handling, sticky NX, arbitration, hold, reset.
module tb_fcvt_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_data;
  logic [1:0]  req_signed;
  logic [7:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;
  logic [3:0]  rsp_tag;
  logic        rsp_inexact;
  logic        fflags_nx;
  logic        fflags_clr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcvt_sched dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_signed  (req_signed),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_tag     (rsp_tag),
    .rsp_inexact (rsp_inexact),
    .fflags_nx   (fflags_nx),
    .fflags_clr  (fflags_clr),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single request with rsp_ready high; returns at the negedge of the RESP cycle.
  task automatic do_req(input int idx, input logic [31:0] op, input logic sgn,
                        input logic [3:0] tag, input logic [31:0] exp_data, input logic exp_nx);
    @(negedge clk);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_signed[idx] = sgn;
    req_data[idx*32 +: 32] = op;
    req_tag[idx*4 +: 4] = tag;
    rsp_ready = 1'b1;
    #1;
    check("req_ready", 64'(req_ready), 64'(2'b01 << idx));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("conv_rsp_valid", 64'(rsp_valid), 64'd0);
    check("conv_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_inexact", 64'(rsp_inexact), 64'(exp_nx));
    check("rsp_id", 64'(rsp_id), 64'(idx));
    check("rsp_tag", 64'(rsp_tag), 64'(tag));
  endtask

  initial begin
    int w;
    int exp_id;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_signed = '0;
    req_tag = '0;
    rsp_ready = 1'b0;
    fflags_clr = 1'b0;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_nx", 64'(fflags_nx), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(0, 32'd7, 1'b0, 4'h1, 32'h40E00000, 1'b0);
    do_req(1, 32'hFFFFFFFF, 1'b1, 4'h2, 32'hBF800000, 1'b0);
    do_req(1, 32'h80000000, 1'b1, 4'h3, 32'hCF000000, 1'b0);
    do_req(1, 32'h00000000, 1'b1, 4'h4, 32'h00000000, 1'b0);

    // Sticky NX set, clear, then clear and set together.
    do_req(1, 32'hFFFFFFFF, 1'b0, 4'h5, 32'h4F800000, 1'b1);
    @(negedge clk);
    #1;
    check("nx_set", 64'(fflags_nx), 64'd1);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    #1;
    check("nx_clr", 64'(fflags_nx), 64'd0);
    do_req(1, 32'hFFFFFFFF, 1'b0, 4'h6, 32'h4F800000, 1'b1);
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    #1;
    check("nx_set_wins", 64'(fflags_nx), 64'd1);

    // Both requesters held valid; pointer is back at 0 here.
    @(negedge clk);
    req_valid = 2'b11;
    req_signed = 2'b00;
    req_data = {32'd2, 32'd1};
    req_tag = {4'h5, 4'hA};
    rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
`ifdef FCVT_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 2;
`endif
      w = 0;
      @(negedge clk);
      #1;
      while (!rsp_valid && w < 10) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (n > 0) check("stream_gap", 64'(w), 64'd1);
      check("stream_valid", 64'(rsp_valid), 64'd1);
      check("stream_id", 64'(rsp_id), 64'(exp_id));
      check("stream_tag", 64'(rsp_tag), (exp_id == 0) ? 64'hA : 64'h5);
      check("stream_data", 64'(rsp_data), (exp_id == 0) ? 64'h3F800000 : 64'h40000000);
      if (n == 7) req_valid = 2'b00;
    end

    // Response held by backpressure while requester 1 waits.
    @(negedge clk);
    req_data = {32'd5, 32'd3};
    req_tag = {4'h7, 4'h3};
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data", 64'(rsp_data), 64'h40400000);
      check("hold_id_tag", 64'({rsp_id, rsp_tag}), 64'({1'b0, 4'h3}));
      check("hold_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_grant", 64'(req_ready), 64'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("release_conv", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    check("release_rsp_valid", 64'(rsp_valid), 64'd1);
    check("release_rsp_data", 64'(rsp_data), 64'h40A00000);
    check("release_rsp_id", 64'(rsp_id), 64'd1);

    // Reset during CONV drops the request.
    @(negedge clk);
    req_data[31:0] = 32'd9;
    req_tag[3:0] = 4'h9;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rsp_data", 64'(rsp_data), 64'd0);
    check("arst_rsp_id_tag", 64'({rsp_id, rsp_tag}), 64'd0);
    check("arst_rsp_inexact", 64'(rsp_inexact), 64'd0);
    check("arst_nx", 64'(fflags_nx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("dropped_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(1, 32'h00000010, 1'b0, 4'hC, 32'h41800000, 1'b0);
    @(negedge clk);
    #1;
    check("final_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
